rob_complete_arbiter: RTL

Collects finished results from the functional units and drives them onto the reorder buffer's three completion ports.
- Each FU gets a small result FIFO with a valid/ready handshake.
- Each cycle, up to three non-empty FIFOs are granted in round-robin order. Their head entries go out on registered completion outputs.
- Sits between the execute stage and the ROB; the ROB is the receiver of this block's output.

---
 rtl/rob_complete_arbiter_if.sv | 62 ++++++
 rtl/rob_complete_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_complete_arbiter_if.sv
// -----------------------------------------------------------------------------
// rob_complete_arbiter_if
// Bundles the functional-unit result handshake and the three ROB completion
// ports of rob_complete_arbiter.
//
//   slave  : arbiter side (consumes FU results, drives completion ports)
//   master : producer / environment side (drives FU results, sees completions)
//
// Signals
//   fu_valid_i     [NUM_FU]            per-FU result valid
//   fu_ready_o     [NUM_FU]            per-FU ready (FIFO not full)
//   fu_rob_indx_i  [NUM_FU*IW]         packed ROB index, FU k at [k*IW +: IW]
//   fu_pc_i        [NUM_FU*PC_SIZE]    packed PC
//   fu_val_i       [NUM_FU*WORD_SIZE]  packed result value
//   en_complete_instrN_o               completion port N valid (N = 0..2)
//   complete_indxN_o / complete_pcN_o / complete_valN_o   completion payload
// -----------------------------------------------------------------------------
interface rob_complete_arbiter_if #(
    parameter int NUM_FU    = 4,
    parameter int WORD_SIZE = 32,
    parameter int PC_SIZE   = 32,
    parameter int ROB_SIZE  = 16
);
    localparam int IW = $clog2(ROB_SIZE);

    logic [NUM_FU-1:0]           fu_valid_i;
    logic [NUM_FU-1:0]           fu_ready_o;
    logic [NUM_FU*IW-1:0]        fu_rob_indx_i;
    logic [NUM_FU*PC_SIZE-1:0]   fu_pc_i;
    logic [NUM_FU*WORD_SIZE-1:0] fu_val_i;

    logic                        en_complete_instr0_o;
    logic                        en_complete_instr1_o;
    logic                        en_complete_instr2_o;
    logic [IW-1:0]               complete_indx0_o;
    logic [IW-1:0]               complete_indx1_o;
    logic [IW-1:0]               complete_indx2_o;
    logic [PC_SIZE-1:0]          complete_pc0_o;
    logic [PC_SIZE-1:0]          complete_pc1_o;
    logic [PC_SIZE-1:0]          complete_pc2_o;
    logic [WORD_SIZE-1:0]        complete_val0_o;
    logic [WORD_SIZE-1:0]        complete_val1_o;
    logic [WORD_SIZE-1:0]        complete_val2_o;

    modport slave (
        input  fu_valid_i, fu_rob_indx_i, fu_pc_i, fu_val_i,
        output fu_ready_o,
        output en_complete_instr0_o, en_complete_instr1_o, en_complete_instr2_o,
        output complete_indx0_o, complete_indx1_o, complete_indx2_o,
        output complete_pc0_o, complete_pc1_o, complete_pc2_o,
        output complete_val0_o, complete_val1_o, complete_val2_o
    );

    modport master (
        output fu_valid_i, fu_rob_indx_i, fu_pc_i, fu_val_i,
        input  fu_ready_o,
        input  en_complete_instr0_o, en_complete_instr1_o, en_complete_instr2_o,
        input  complete_indx0_o, complete_indx1_o, complete_indx2_o,
        input  complete_pc0_o, complete_pc1_o, complete_pc2_o,
        input  complete_val0_o, complete_val1_o, complete_val2_o
    );
endinterface

// File: rtl/rob_complete_arbiter.sv
// -----------------------------------------------------------------------------
// rob_complete_arbiter
// Buffers finished results from NUM_FU functional units in per-FU FIFOs and
// forwards up to three of them per cycle onto the ROB completion ports, using
// a round-robin scan that starts at rr_ptr. Completion outputs are registered
// and valid for exactly one cycle; the ROB never back-pressures.
//
// Ports
//   clk_i    clock, all state updates on posedge
//   rst_i    asynchronous active-high reset
//   flush_i  synchronous flush: drops buffered results, discards the pushes
//            of that edge, suppresses pops and resets rr_ptr
//   bus      rob_complete_arbiter_if.slave (FU handshake + completion ports)
//
// Optional feature macro: COMPLETE_ARB_BYPASS_EN
//   When defined, an empty FIFO whose FU presents a valid result competes in
//   the same cycle's arbitration with the input as its head; if granted the
//   result goes straight to the output register and is never enqueued.
// -----------------------------------------------------------------------------
module rob_complete_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_SIZE  = 32,
    parameter int PC_SIZE    = 32,
    parameter int ROB_SIZE   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    rob_complete_arbiter_if.slave bus
);
    localparam int IW = $clog2(ROB_SIZE);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(NUM_FU);

    // unpacked FU inputs
    logic [IW-1:0]        in_indx [NUM_FU];
    logic [PC_SIZE-1:0]   in_pc   [NUM_FU];
    logic [WORD_SIZE-1:0] in_val  [NUM_FU];

    // FIFO storage and bookkeeping
    logic [IW-1:0]        mem_indx_q [NUM_FU][FIFO_DEPTH];
    logic [PC_SIZE-1:0]   mem_pc_q   [NUM_FU][FIFO_DEPTH];
    logic [WORD_SIZE-1:0] mem_val_q  [NUM_FU][FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr_q   [NUM_FU];
    logic [AW-1:0]        rd_ptr_d   [NUM_FU];
    logic [AW-1:0]        wr_ptr_q   [NUM_FU];
    logic [AW-1:0]        wr_ptr_d   [NUM_FU];
    logic [CW-1:0]        count_q    [NUM_FU];
    logic [CW-1:0]        count_d    [NUM_FU];

    // head of each source as seen by the arbiter
    logic [IW-1:0]        head_indx [NUM_FU];
    logic [PC_SIZE-1:0]   head_pc   [NUM_FU];
    logic [WORD_SIZE-1:0] head_val  [NUM_FU];

    logic [NUM_FU-1:0]    ready;
    logic [NUM_FU-1:0]    cand;
    logic [NUM_FU-1:0]    granted;
    logic [NUM_FU-1:0]    pop;
    logic [NUM_FU-1:0]    push;
    logic [NUM_FU-1:0]    byp_take;

    // arbiter results
    logic [2:0]           gnt_vld;
    logic [FW-1:0]        gnt_fu [3];
    logic [FW-1:0]        last_fu;
    logic [FW-1:0]        rr_ptr_q;
    logic [FW-1:0]        rr_ptr_d;

    // registered completion ports
    logic [2:0]           en_q;
    logic [IW-1:0]        out_indx_q [3];
    logic [PC_SIZE-1:0]   out_pc_q   [3];
    logic [WORD_SIZE-1:0] out_val_q  [3];

    for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
        assign in_indx[g] = bus.fu_rob_indx_i[g*IW +: IW];
        assign in_pc[g]   = bus.fu_pc_i[g*PC_SIZE +: PC_SIZE];
        assign in_val[g]  = bus.fu_val_i[g*WORD_SIZE +: WORD_SIZE];
    end

    // Ready depends on the registered count only: a full FIFO refuses a
    // push even if it is being popped on the same edge.
    always_comb begin
        ready = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            ready[k] = (count_q[k] != CW'(FIFO_DEPTH));
        end
    end

    assign bus.fu_ready_o = ready;

    always_comb begin
        cand = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            head_indx[k] = mem_indx_q[k][rd_ptr_q[k]];
            head_pc[k]   = mem_pc_q[k][rd_ptr_q[k]];
            head_val[k]  = mem_val_q[k][rd_ptr_q[k]];
            cand[k]      = (count_q[k] != '0);
`ifdef COMPLETE_ARB_BYPASS_EN
            if (count_q[k] == '0) begin
                head_indx[k] = in_indx[k];
                head_pc[k]   = in_pc[k];
                head_val[k]  = in_val[k];
                cand[k]      = bus.fu_valid_i[k];
            end
`endif
        end
    end

    // Round-robin scan: walk FUs from rr_ptr with wrap, hand out ports 0,1,2
    // to the first three candidates. Each FU is visited once, so no FIFO can
    // receive two ports in the same cycle.
    always_comb begin
        logic [FW:0] sum;
        logic [1:0]  n;
        sum     = '0;
        n       = 2'd0;
        gnt_vld = '0;
        granted = '0;
        last_fu = '0;
        for (int p = 0; p < 3; p++) begin
            gnt_fu[p] = '0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            sum = {1'b0, rr_ptr_q} + (FW+1)'(i);
            if (sum >= (FW+1)'(NUM_FU)) begin
                sum = sum - (FW+1)'(NUM_FU);
            end
            if (cand[sum[FW-1:0]] && (n != 2'd3)) begin
                gnt_vld[n]            = 1'b1;
                gnt_fu[n]             = sum[FW-1:0];
                granted[sum[FW-1:0]]  = 1'b1;
                last_fu               = sum[FW-1:0];
                n                     = n + 2'd1;
            end
        end
    end

    // A bypassed result leaves straight through the output register and
    // never occupies the FIFO; only grants of stored entries pop.
    always_comb begin
        pop      = '0;
        push     = '0;
        byp_take = '0;
        for (int k = 0; k < NUM_FU; k++) begin
`ifdef COMPLETE_ARB_BYPASS_EN
            byp_take[k] = granted[k] && (count_q[k] == '0);
`endif
            pop[k]  = granted[k] && (count_q[k] != '0) && !flush_i;
            push[k] = bus.fu_valid_i[k] && ready[k] && !flush_i && !byp_take[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            if (flush_i) begin
                count_d[k]  = '0;
                rd_ptr_d[k] = '0;
                wr_ptr_d[k] = '0;
            end else begin
                count_d[k]  = count_q[k] + CW'(push[k]) - CW'(pop[k]);
                rd_ptr_d[k] = rd_ptr_q[k] + AW'(pop[k]);
                wr_ptr_d[k] = wr_ptr_q[k] + AW'(push[k]);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (gnt_vld != '0) begin
            if (last_fu == FW'(NUM_FU - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = last_fu + FW'(1);
            end
        end
    end

    // FIFO payload storage carries no reset; validity lives in count_q.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_FU; k++) begin
            if (push[k]) begin
                mem_indx_q[k][wr_ptr_q[k]] <= in_indx[k];
                mem_pc_q[k][wr_ptr_q[k]]   <= in_pc[k];
                mem_val_q[k][wr_ptr_q[k]]  <= in_val[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_FU; k++) begin
                count_q[k]  <= '0;
                rd_ptr_q[k] <= '0;
                wr_ptr_q[k] <= '0;
            end
            rr_ptr_q <= '0;
            en_q     <= '0;
            for (int p = 0; p < 3; p++) begin
                out_indx_q[p] <= '0;
                out_pc_q[p]   <= '0;
                out_val_q[p]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                count_q[k]  <= count_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                wr_ptr_q[k] <= wr_ptr_d[k];
            end
            rr_ptr_q <= rr_ptr_d;
            // Ports without a grant drop their valid but keep their payload.
            for (int p = 0; p < 3; p++) begin
                en_q[p] <= gnt_vld[p] && !flush_i;
                if (gnt_vld[p] && !flush_i) begin
                    out_indx_q[p] <= head_indx[gnt_fu[p]];
                    out_pc_q[p]   <= head_pc[gnt_fu[p]];
                    out_val_q[p]  <= head_val[gnt_fu[p]];
                end
            end
        end
    end

    assign bus.en_complete_instr0_o = en_q[0];
    assign bus.en_complete_instr1_o = en_q[1];
    assign bus.en_complete_instr2_o = en_q[2];
    assign bus.complete_indx0_o     = out_indx_q[0];
    assign bus.complete_indx1_o     = out_indx_q[1];
    assign bus.complete_indx2_o     = out_indx_q[2];
    assign bus.complete_pc0_o       = out_pc_q[0];
    assign bus.complete_pc1_o       = out_pc_q[1];
    assign bus.complete_pc2_o       = out_pc_q[2];
    assign bus.complete_val0_o      = out_val_q[0];
    assign bus.complete_val1_o      = out_val_q[1];
    assign bus.complete_val2_o      = out_val_q[2];

endmodule
